radix4_otf_converter: RTL
=========================

Name: radix4_otf_converter

Overview:
- Downstream of radix4multiplier: consumes its MSD-first radix-4 signed-digit output stream z (3-bit digits) and converts it on the fly to a conventional two's-complement word.
- Uses the Q/QM on-the-fly conversion registers, so no carry-propagate adder is needed.
- Skips the multiplier's online delay, accumulates NO_OF_DIGITS digits and presents the result with a one-cycle valid pulse.

Parameters:
- NO_OF_DIGITS, 4, digits per result frame.
- RADIX_BITS, 3, width of one signed digit (two's complement).
- DELTA, 2, leading digits discarded after sof (the multiplier's online delay).
- RES_W, 2*NO_OF_DIGITS+1, result width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sof  in  1  start of frame; qualified by in_valid; marks the cycle the first operand digit entered the multiplier.
- in_valid  in  1  digit_in valid this cycle.
- digit_in  in  RADIX_BITS  signed digit; legal -3..+3; 3'b100 illegal.
- result  out  RES_W  signed fraction scaled by 4^NO_OF_DIGITS.
- out_valid  out  1  one-cycle pulse; result is new.
- frame_err  out  1  one-cycle pulse: sof arrived mid-frame, partial frame aborted.
- digit_err  out  1  sticky: illegal digit seen in the current or last frame; cleared by the next accepted sof.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, Q=0, QM=all ones.
  - result=0, out_valid=0, frame_err=0, digit_err=0.
- States: IDLE, SKIP, ACCUM. All transitions require in_valid=1; in_valid=0 stalls everything and counters hold.
- IDLE:
  - sof&in_valid: load Q=0, QM=-1, cnt=0, clear digit_err.
  - If DELTA=0, the sof digit is accumulated as digit 1 and the next state is ACCUM.
  - Otherwise the sof digit counts as skip 1: go to SKIP if DELTA>1, else to ACCUM.
  - Non-sof digits in IDLE are ignored.
- SKIP: discard digits until DELTA digits (including the sof digit) have been skipped, then go to ACCUM.
- ACCUM: each valid digit z updates both registers, with the width truncated to RES_W:
  - Q := (z>=0) ? {Q[RES_W-3:0], z[1:0]} : {QM[RES_W-3:0], (z+4)[1:0]}.
  - QM := (z>0) ? {Q[RES_W-3:0], (z-1)[1:0]} : {QM[RES_W-3:0], (z+3)[1:0]}.
  - Invariant: QM = Q-1 and Q = sum z_j*4^(k-j).
- Completion: on the NO_OF_DIGITS-th accumulated digit:
  - result <= the updated Q and out_valid=1 in the next cycle. Latency is one clock from sampling the last digit.
  - state returns to IDLE.
  - result holds until the next completion.
- Simultaneous events:
  - sof in the same cycle out_valid is high is legal: the new frame starts and the output is unaffected.
  - sof while in SKIP or ACCUM (including on the last-digit cycle): abort the frame and pulse frame_err next cycle. The sof digit then starts a new frame exactly as from IDLE. No out_valid for the aborted frame; result is unchanged.
- Illegal digit 3'b100: treated as 0 in the update; sets digit_err. Digits discarded in SKIP are also checked.
- Range: |value| <= 4^N-1, so the result always fits RES_W bits. No overflow is possible.
- Reset mid-frame: immediate return to reset values; the partial frame is lost and no pulse is generated.

Decomposition:
- Shared package radix4_pkg:
  - digit width constant RADIX_BITS=3.
  - DIGIT_MIN=-3, DIGIT_MAX=3, ILLEGAL_DIGIT=3'b100.
  - state enum {IDLE, SKIP, ACCUM}.
  - RES_W function of NO_OF_DIGITS.
- One natural sub-module, otf_digit_append: combinational Q/QM next-value logic for one digit, reusable by a future divider stage.
- FSM, counter and output register stay in the top.

Test Plan (N=4, DELTA=2):
- Frame: sof with 2 junk digits, then digits 1,0,0,0 -> one cycle after the 4th digit, out_valid=1, result=9'b0_0100_0000 (+64).
- Digits -1,2,-3,1 -> result=9'b1_1101_0101 (-43); checks the QM path on negative digits.
- Extremes: 3,3,3,3 -> 9'b0_1111_1111 (+255). -3,-3,-3,-3 -> 9'b1_0000_0001 (-255).
- in_valid deasserted for 3 cycles between digits 2 and 3 of the +64 frame -> identical result; out_valid delayed by exactly 3 cycles.
- sof reasserted after 2 accumulated digits -> frame_err pulse; no out_valid for the aborted frame; the new frame 0,0,0,1 completes with result=+1.
- Digit 3'b100 in ACCUM -> digit_err=1 and result as if that digit were 0. Next sof clears digit_err. rst_n pulled low mid-ACCUM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/radix4_pkg.sv
// Shared definitions for radix-4 signed-digit stages: digit encoding, FSM states
// and the result-width rule.
package radix4_pkg;

  localparam int RADIX_BITS = 3;
  localparam int DIGIT_MIN  = -3;
  localparam int DIGIT_MAX  = 3;
  localparam logic [RADIX_BITS-1:0] ILLEGAL_DIGIT = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // Two bits per radix-4 digit plus a sign bit.
  function automatic int res_width(input int no_of_digits);
    return 2 * no_of_digits + 1;
  endfunction

endpackage

// File: rtl/otf_digit_append.sv
// Combinational Q/QM on-the-fly conversion step: appends one signed radix-4 digit
// to the Q (value) and QM (value - 1) registers without any carry propagation.
module otf_digit_append
  import radix4_pkg::*;
#(
  parameter int RES_W = 9
) (
  input  logic [RES_W-1:0]      q,
  input  logic [RES_W-1:0]      qm,
  input  logic [RADIX_BITS-1:0] digit,
  output logic [RES_W-1:0]      q_next,
  output logic [RES_W-1:0]      qm_next,
  output logic                  illegal
);

  logic [RADIX_BITS-1:0] z;
  logic [1:0]            low;
  logic [1:0]            low_m1;
  logic                  neg;
  logic                  pos;

  always_comb begin
    illegal = (digit == ILLEGAL_DIGIT);
    z       = illegal ? '0 : digit;
    neg     = z[RADIX_BITS-1];
    pos     = !neg && (z != '0);
    // (z+4) mod 4 equals z mod 4, and (z-1) mod 4 equals (z+3) mod 4.
    low     = z[1:0];
    low_m1  = z[1:0] - 2'd1;
    q_next  = ((neg ? qm : q) << 2) | RES_W'(low);
    qm_next = ((pos ? q : qm) << 2) | RES_W'(low_m1);
  end

endmodule

// File: rtl/radix4_otf_converter.sv
// Converts an MSD-first radix-4 signed-digit stream into a two's-complement word,
// discarding the producer's online delay and pulsing out_valid per frame.
module radix4_otf_converter
  import radix4_pkg::*;
#(
  parameter  int NO_OF_DIGITS = 4,
  parameter  int DELTA        = 2,
  localparam int RES_W        = res_width(NO_OF_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof,
  input  logic                  in_valid,
  input  logic [RADIX_BITS-1:0] digit_in,
  output logic [RES_W-1:0]      result,
  output logic                  out_valid,
  output logic                  frame_err,
  output logic                  digit_err,
  output state_t                dbg_state
);

  localparam int CNT_MAX = (NO_OF_DIGITS > DELTA) ? NO_OF_DIGITS : DELTA;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((DELTA > 0) ? DELTA - 1 : 0);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(NO_OF_DIGITS - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next, acc_cnt;
  logic [RES_W-1:0]   q, qm, base_q, base_qm, q_next, qm_next;
  logic               start, accumulate, complete, illegal;

  // A new frame appends onto the reset values, so an abort needs no extra cycle.
  assign start   = in_valid && sof;
  assign base_q  = start ? '0 : q;
  assign base_qm = start ? '1 : qm;
  assign acc_cnt = start ? '0 : cnt;

  otf_digit_append #(.RES_W(RES_W)) u_append (
    .q       (base_q),
    .qm      (base_qm),
    .digit   (digit_in),
    .q_next  (q_next),
    .qm_next (qm_next),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accumulate = 1'b0;
    complete   = 1'b0;
    if (in_valid) begin
      if (sof) begin
        if (DELTA == 0) begin
          accumulate = 1'b1;
        end else begin
          state_next = (DELTA == 1) ? ACCUM : SKIP;
        end
        cnt_next = (DELTA == 1) ? '0 : CNT_W'(1);
      end else begin
        case (state)
          SKIP: begin
            if (cnt == SKIP_LAST) begin
              state_next = ACCUM;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
          ACCUM: begin
            accumulate = 1'b1;
            cnt_next   = cnt + 1'b1;
          end
          default: ;
        endcase
      end
      if (accumulate) begin
        state_next = ACCUM;
        if (acc_cnt == ACC_LAST) begin
          complete   = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      qm        <= '1;
      result    <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      out_valid <= complete;
      frame_err <= start && (state != IDLE);
      if (start) begin
        q         <= '0;
        qm        <= '1;
        digit_err <= illegal;
      end else if (in_valid && (state != IDLE) && illegal) begin
        digit_err <= 1'b1;
      end
      if (accumulate) begin
        q  <= q_next;
        qm <= qm_next;
      end
      if (complete) begin
        result <= q_next;
      end
    end
  end

  assign dbg_state = state;

endmodule
